// File: rtl/mealy_pkg.sv
// rtl/mealy_pkg.sv - shared state type and pattern constants for the 101 detector
package mealy_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_10   = 2'b10
    } state_t;

    localparam int PATTERN_LEN = 3;

    // First bit received is the MSB.
    localparam logic [PATTERN_LEN-1:0] PATTERN = 3'b101;

endpackage

// File: rtl/mealy.sv
// rtl/mealy.sv - overlapping 101 serial sequence detector, Mealy output
module mealy
    import mealy_pkg::*;
(
    input  logic din,
    input  logic reset,
    input  logic clk,
    output logic y
);

    // Declaration initializer gives a defined state even if reset never asserts.
    state_t state = S_IDLE;
    state_t next_state;

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and detect flag; the final 1 of a match leaves us in S_1 so matches overlap.
    always_comb begin
        next_state = S_IDLE;
        y          = 1'b0;
        case (state)
            S_IDLE: begin
                next_state = din ? S_1 : S_IDLE;
            end
            S_1: begin
                next_state = din ? S_1 : S_10;
            end
            S_10: begin
                next_state = din ? S_1 : S_IDLE;
                y          = (din == PATTERN[0]);
            end
            default: begin
                next_state = S_IDLE;
                y          = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mealy.sv
// tb/tb_mealy.sv - self-checking bench for the 101 detector
module tb_mealy;
    import mealy_pkg::*;

    logic din;
    logic reset;
    logic clk;
    logic y;

    int checks;
    int errors;
    int pulses;

    // Reference history: bits seen since the last reset, newest last.
    bit hist [$];

    mealy dut (
        .din   (din),
        .reset (reset),
        .clk   (clk),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_y(input bit d);
        int n;
        n = hist.size();
        if (n < 2) return 1'b0;
        return (hist[n-2] == 1'b1) && (hist[n-1] == 1'b0) && (d == 1'b1);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        checks++;
        assert (dut.state === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, dut.state, exp);
        end
    endtask

    // Drive one bit, check y mid-cycle against the model (and a directed value
    // when chk_exp is set), then consume the clock edge and land on the next negedge.
    task automatic step(input string tag, input bit d, input bit r,
                        input bit chk_exp, input bit exp);
        bit m;
        din   = d;
        reset = r;
        #2;
        m = model_y(d);
        check_bit({tag, "_model"}, y, m);
        if (chk_exp) check_bit(tag, y, exp);
        if (y === 1'b1) pulses++;
        @(posedge clk);
        if (r) hist.delete();
        else begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        bit seq23 [12];
        bit exp23 [12];
        checks = 0;
        errors = 0;
        pulses = 0;
        din    = 1'b0;
        reset  = 1'b0;

        // Time-zero state, no reset ever applied.
        #1;
        check_state("init_state", S_IDLE);
        check_bit("init_y", y, 1'b0);
        #(-1 + 1);

        // Directed waveform: y high only in cycles starting at 30, 50, 70, 110 ns.
        seq23 = '{0,1,0,1,0,1,0,1,1,1,0,1};
        exp23 = '{0,0,0,1,0,1,0,1,0,0,0,1};
        for (int i = 0; i < 12; i++) step("wave", seq23[i], 1'b0, 1'b1, exp23[i]);

        // Reset then a run of five 1s: stays in S_1, no detect.
        step("rst_a", 1'b0, 1'b1, 1'b0, 1'b0);
        check_state("rst_a_state", S_IDLE);
        for (int i = 0; i < 5; i++) step("ones", 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("ones_state", S_1);

        // 1,0,0,1: second 0 drops back to idle.
        step("rst_b", 1'b0, 1'b1, 1'b0, 1'b0);
        step("p1001_0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("p1001_1", 1'b0, 1'b0, 1'b1, 1'b0);
        step("p1001_2", 1'b0, 1'b0, 1'b1, 1'b0);
        check_state("p1001_idle", S_IDLE);
        step("p1001_3", 1'b1, 1'b0, 1'b1, 1'b0);

        // 1,0 then reset mid-pattern, then 1: no detect.
        step("rst_c", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("mid_1", 1'b0, 1'b0, 1'b1, 1'b0);
        check_state("mid_s10", S_10);
        step("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0);
        check_state("mid_rst_state", S_IDLE);
        step("mid_2", 1'b1, 1'b0, 1'b1, 1'b0);

        // 1,0,1,0,1: exactly two one-cycle pulses on the 3rd and 5th bits.
        step("rst_d", 1'b0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        step("ov_0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("ov_1", 1'b0, 1'b0, 1'b1, 1'b0);
        step("ov_2", 1'b1, 1'b0, 1'b1, 1'b1);
        step("ov_3", 1'b0, 1'b0, 1'b1, 1'b0);
        step("ov_4", 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        assert (pulses == 2) else begin
            errors++;
            $error("FAIL ov_pulses observed=%0d expected=2", pulses);
        end

        // Random din for 1000 cycles, occasional reset, against the history model.
        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'($urandom), ($urandom_range(0, 49) == 0), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
